pdm_decimator: RTL and testbench
================================

PDM_DECIMATOR -- requirements
Module: pdm_decimator

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50: clk cycles per micClk period; even, >=4.
REQ-002 SHALL have parameter DECIM, default 64: PDM bits per PCM sample; power of two, 16..256.
REQ-003 SHALL have parameter GAIN_SHIFT, default 8: left shift applied to the signed window sum.
REQ-004 SHALL have port clk, input, 1: system clock; the only clock.
REQ-005 SHALL have port reset_L, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port enable, input, 1: run capture when high.
REQ-007 SHALL have port micData, input, 1: PDM bit from the microphone, asynchronous to clk.
REQ-008 SHALL have port micClk, output, 1: PDM bit clock to the microphone.
REQ-009 SHALL have port sample, output, 16: signed two's-complement PCM sample.
REQ-010 SHALL have port sample_valid, output, 1: sample holds an unconsumed value.
REQ-011 SHALL have port sample_ready, input, 1: the consumer (speech recognizer / recorder) accepts sample.
REQ-012 SHALL have port overrun, output, 1: sticky flag; a finished sample was dropped.

Function
REQ-013 SHALL drive micClk low for CLK_DIV/2 clk cycles, then high for CLK_DIV/2, from a registered divider; micClk SHALL be held low while enable=0.
REQ-014 SHALL pass micData through a two-flop synchronizer before any use.
REQ-015 SHALL assert an internal rise tick in the clk cycle in which micClk goes 0->1, and SHALL capture the synchronized micData bit only on that tick.
REQ-016 SHALL count captured ones (0..DECIM) and captured bits over a window of exactly DECIM bits.
REQ-017 SHALL compute, on the tick that captures the DECIM-th bit, pcm = (2*ones - DECIM) << GAIN_SHIFT, evaluated at 24 bits and saturated to [-32768, 32767].
REQ-018 SHALL clear ones and the bit count in the same cycle the window completes, so that the next bit starts a new window with no gap.
REQ-019 SHALL load pcm into the output register and assert sample_valid 1 cycle after the completing tick (2 cycles with PDM_DC_BLOCK_EN).
REQ-020 SHALL complete a handshake when sample_valid && sample_ready; sample_valid SHALL drop in the next cycle unless a new sample loads in that same cycle.
REQ-021 SHALL, when a new pcm is ready while sample_valid=1 and sample_ready=0, keep the old sample, discard the new one, and set overrun=1.
REQ-022 SHALL load a new pcm without overrun when it arrives in the same cycle as a handshake.
REQ-023 SHALL, when enable falls mid-window, discard the partial window and restart the divider at the low phase.
REQ-024 SHALL, after enable rises, emit its first tick CLK_DIV/2 cycles later.
REQ-025 SHALL keep a pending sample valid across enable=0 until it is accepted.
REQ-026 SHALL keep overrun set until reset.

Reset
REQ-027 SHALL, while reset_L=0, force micClk=0, sample=0, sample_valid=0, overrun=0, and clear the divider, counters, synchronizer and DC state.
REQ-028 SHALL emit no sample from a window interrupted by reset; capture SHALL restart per REQ-024.

Configuration
REQ-029 SHALL, when PDM_DC_BLOCK_EN is defined, output y = pcm - avg with avg (24-bit signed, reset 0) updated per sample as avg += (pcm - avg) >>> 8 after y is formed; y SHALL be saturated to 16 bits and add exactly one cycle of latency.
REQ-030 SHALL, when PDM_DC_BLOCK_EN is undefined, output pcm directly with no avg register present.

Structure
REQ-031 SHALL take PCM_W=16 and typedef pcm_t (logic signed [15:0]) from shared package voice_pkg, which the downstream recognizer also uses.
REQ-032 SHALL place the divider and tick generation in sub-module pdm_clkgen (ports clk, reset_L, enable, micClk, tick).

Verification (defaults, DC block off unless noted)
REQ-033 SHALL verify: micData=1 constant, sample_ready=1 -> sample=0x4000 every 3200 clk cycles; micClk period 50 cycles, 25 high.
REQ-034 SHALL verify: micData=0 constant -> sample=0xC000; alternating 1/0 per tick -> sample=0x0000.
REQ-035 SHALL verify: sample_ready=0 across two windows -> first sample held, overrun=1 from the second completion; ready=1 then yields one handshake, and overrun stays 1.
REQ-036 SHALL verify: reset_L pulsed low at bit 30 of a window -> all outputs 0 immediately; first post-reset sample reflects only post-reset bits.
REQ-037 SHALL verify: enable dropped at bit 40 -> micClk low, no sample; re-enable -> first tick after 25 cycles, full 64-bit window.
REQ-038 SHALL verify, with PDM_DC_BLOCK_EN and micData=1 constant: first sample 0x4000, second 0x3FC0, monotonically decaying toward 0.

Source files
------------

// File: rtl/voice_pkg.sv
// Shared PCM definitions used by the PDM front end and the downstream recognizer.
package voice_pkg;
  localparam int PCM_W = 16;

  typedef logic signed [PCM_W-1:0] pcm_t;

  function automatic pcm_t sat_pcm(input logic signed [23:0] v);
    if (v > 24'sd32767) begin
      return 16'sh7FFF;
    end else if (v < -24'sd32768) begin
      return 16'sh8000;
    end else begin
      return pcm_t'(v[PCM_W-1:0]);
    end
  endfunction
endpackage

// File: rtl/pdm_clkgen.sv
// PDM bit-clock divider: micClk low for CLK_DIV/2 cycles, then high; tick marks the 0->1 cycle.
module pdm_clkgen #(
  parameter int CLK_DIV = 50
) (
  input  logic clk,
  input  logic reset_L,
  input  logic enable,
  output logic micClk,
  output logic tick
);
  localparam int CW   = $clog2(CLK_DIV);
  localparam int HALF = CLK_DIV / 2;

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = (cnt == CW'(CLK_DIV - 1)) ? '0 : cnt + CW'(1);
  end

  // Disabling parks the divider at count 0 so re-enable always starts with a full low phase.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      cnt    <= '0;
      micClk <= 1'b0;
      tick   <= 1'b0;
    end else if (!enable) begin
      cnt    <= '0;
      micClk <= 1'b0;
      tick   <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      micClk <= (cnt_nxt >= CW'(HALF));
      tick   <= (cnt_nxt == CW'(HALF));
    end
  end
endmodule

// File: rtl/pdm_decimator.sv
// PDM-to-PCM decimator: box-car ones count over DECIM bits, scaled and saturated to 16 bits.
// Optional DC-blocking high-pass stage is built when PDM_DC_BLOCK_EN is defined.
module pdm_decimator
  import voice_pkg::*;
#(
  parameter int CLK_DIV    = 50,
  parameter int DECIM      = 64,
  parameter int GAIN_SHIFT = 8
) (
  input  logic clk,
  input  logic reset_L,
  input  logic enable,
  input  logic micData,
  output logic micClk,
  output pcm_t sample,
  output logic sample_valid,
  input  logic sample_ready,
  output logic overrun
);
  localparam int OW = $clog2(DECIM + 1);
  localparam int BW = $clog2(DECIM);

  logic          tick;
  logic          cap;
  logic          last;
  logic          mic_s1;
  logic          mic_s2;
  logic [OW-1:0] ones;
  logic [BW-1:0] bit_cnt;

  logic [23:0]        ones_tot;
  logic signed [23:0] diff;
  logic signed [23:0] scaled;
  pcm_t               pcm;
  pcm_t               new_pcm;
  logic               new_valid;

  pdm_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk     (clk),
    .reset_L (reset_L),
    .enable  (enable),
    .micClk  (micClk),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      mic_s1 <= 1'b0;
      mic_s2 <= 1'b0;
    end else begin
      mic_s1 <= micData;
      mic_s2 <= mic_s1;
    end
  end

  assign cap  = tick && enable;
  assign last = cap && (bit_cnt == BW'(DECIM - 1));

  // The completing bit is folded in combinationally so the counters clear on that same tick.
  always_comb begin
    ones_tot = 24'(ones) + 24'(mic_s2);
    diff     = signed'((ones_tot << 1) - 24'(DECIM));
    scaled   = diff <<< GAIN_SHIFT;
    pcm      = sat_pcm(scaled);
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      ones    <= '0;
      bit_cnt <= '0;
    end else if (!enable || last) begin
      ones    <= '0;
      bit_cnt <= '0;
    end else if (cap) begin
      ones    <= ones + OW'(mic_s2);
      bit_cnt <= bit_cnt + BW'(1);
    end
  end

`ifdef PDM_DC_BLOCK_EN
  pcm_t               pcm_d;
  logic               pend;
  logic signed [23:0] pcm_ext;
  logic signed [23:0] avg;

  always_comb begin
    pcm_ext   = {{8{pcm_d[PCM_W-1]}}, pcm_d};
    new_pcm   = sat_pcm(pcm_ext - avg);
    new_valid = pend;
  end

  // avg moves toward pcm only after y has been formed from the old avg.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      pcm_d <= '0;
      pend  <= 1'b0;
      avg   <= '0;
    end else begin
      pend <= last;
      if (last) begin
        pcm_d <= pcm;
      end
      if (pend) begin
        avg <= avg + ((pcm_ext - avg) >>> 8);
      end
    end
  end
`else
  always_comb begin
    new_pcm   = pcm;
    new_valid = last;
  end
`endif

  // Handshake: a transfer occurs on any clk edge where sample_valid && sample_ready; sample
  // is stable while valid is high and unaccepted, and a new pcm then is dropped (overrun).
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      sample       <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else if (new_valid) begin
      if (!sample_valid || sample_ready) begin
        sample       <= new_pcm;
        sample_valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (sample_valid && sample_ready) begin
      sample_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_pdm_decimator.sv
// Directed bench for pdm_decimator (default build) plus a high-gain instance for saturation.
module tb_pdm_decimator;
  logic        clk;
  logic        reset_L;
  logic        enable;
  logic        micData;
  logic        sample_ready;
  logic        micClk;
  logic [15:0] sample;
  logic        sample_valid;
  logic        overrun;
  logic        micClk_s;
  logic [15:0] sample_s;
  logic        sample_valid_s;
  logic        overrun_s;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  logic [15:0] exp_q[$];
  logic [15:0] sat_q[$];

  logic run_chk   = 1'b0;
  logic have_prev = 1'b0;
  int   prev_cyc  = 0;
  logic have_rise = 1'b0;
  int   rise_cyc  = 0;
  logic mc_prev   = 1'b0;

  typedef struct {
    int          mode;
    logic [15:0] exp;
    logic [15:0] exp_sat;
  } vec_t;

  vec_t vecs[6];

  pdm_decimator dut (
    .clk          (clk),
    .reset_L      (reset_L),
    .enable       (enable),
    .micData      (micData),
    .micClk       (micClk),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun)
  );

  pdm_decimator #(.GAIN_SHIFT(10)) dut_sat (
    .clk          (clk),
    .reset_L      (reset_L),
    .enable       (enable),
    .micData      (micData),
    .micClk       (micClk_s),
    .sample       (sample_s),
    .sample_valid (sample_valid_s),
    .sample_ready (1'b1),
    .overrun      (overrun_s)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // scoreboard + micClk timing monitor
  always @(negedge clk) begin
    logic [15:0] e;
    if (sample_valid && sample_ready) begin
      if (exp_q.size() == 0) begin
        n_total++;
        n_bad++;
        $display("FAIL unexpected_sample: got %h want none", sample);
      end else begin
        e = exp_q.pop_front();
        check("sample", {16'h0, sample}, {16'h0, e});
      end
      if (run_chk && have_prev) check("sample_period", cyc - prev_cyc, 3200);
      prev_cyc  = cyc;
      have_prev = run_chk;
    end
    if (sample_valid_s) begin
      if (sat_q.size() == 0) begin
        n_total++;
        n_bad++;
        $display("FAIL unexpected_sat_sample: got %h want none", sample_s);
      end else begin
        e = sat_q.pop_front();
        check("sat_sample", {16'h0, sample_s}, {16'h0, e});
      end
    end
    if (run_chk) begin
      if (micClk && !mc_prev) begin
        if (have_rise) check("micclk_period", cyc - rise_cyc, 50);
        rise_cyc  = cyc;
        have_rise = 1'b1;
      end
      if (!micClk && mc_prev && have_rise) check("micclk_high", cyc - rise_cyc, 25);
    end else begin
      have_rise = 1'b0;
    end
    mc_prev = micClk;
  end

  // driver tasks
  function automatic logic bit_of(input int mode, input int i);
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return (i % 2) == 0;
      3:       return i < 16;
      default: return i < 48;
    endcase
  endfunction

  task automatic wait_mic(input logic lvl);
    int n = 0;
    while (micClk !== lvl && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (micClk !== lvl) begin
      n_total++;
      n_bad++;
      $display("FAIL micclk_wait: got %b want %b", micClk, lvl);
    end
  endtask

  task automatic send_bits(input int mode, input int start, input int n);
    for (int i = start; i < start + n; i++) begin
      wait_mic(1'b0);
      micData = bit_of(mode, i);
      wait_mic(1'b1);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    vecs[0] = '{1, 16'h4000, 16'h7FFF};
    vecs[1] = '{0, 16'hC000, 16'h8000};
    vecs[2] = '{2, 16'h0000, 16'h0000};
    vecs[3] = '{3, 16'hE000, 16'h8000};
    vecs[4] = '{4, 16'h2000, 16'h7FFF};
    vecs[5] = '{1, 16'h4000, 16'h7FFF};

    reset_L      = 1'b0;
    enable       = 1'b0;
    micData      = 1'b0;
    sample_ready = 1'b1;
    step(3);
    check("rst_micclk", micClk, 0);
    check("rst_sample", sample, 0);
    check("rst_valid", sample_valid, 0);
    check("rst_overrun", overrun, 0);
    reset_L = 1'b1;
    step(1);
    enable = 1'b1;

    // back-to-back windows
    run_chk = 1'b1;
    for (int v = 0; v < 6; v++) begin
      exp_q.push_back(vecs[v].exp);
      sat_q.push_back(vecs[v].exp_sat);
      send_bits(vecs[v].mode, 0, 64);
    end
    step(5);
    run_chk = 1'b0;
    check("table_drain", exp_q.size(), 0);

    // overrun: consumer stalls across two windows
    sample_ready = 1'b0;
    sat_q.push_back(16'h7FFF);
    sat_q.push_back(16'h8000);
    send_bits(1, 0, 64);
    step(3);
    check("ovr_valid1", sample_valid, 1);
    check("ovr_sample1", sample, 16'h4000);
    check("ovr_flag1", overrun, 0);
    send_bits(0, 0, 64);
    step(3);
    check("ovr_flag2", overrun, 1);
    check("ovr_held", sample, 16'h4000);
    check("ovr_valid2", sample_valid, 1);
    check("ovr_sat_flag", overrun_s, 0);
    exp_q.push_back(16'h4000);
    sample_ready = 1'b1;
    step(3);
    check("ovr_valid_drop", sample_valid, 0);
    check("ovr_sticky", overrun, 1);

    // reset at bit 30 of a window
    send_bits(1, 0, 30);
    reset_L = 1'b0;
    #1;
    check("mid_rst_micclk", micClk, 0);
    check("mid_rst_sample", sample, 0);
    check("mid_rst_valid", sample_valid, 0);
    check("mid_rst_overrun", overrun, 0);
    step(3);
    reset_L = 1'b1;
    exp_q.push_back(16'hC000);
    sat_q.push_back(16'h8000);
    send_bits(0, 0, 64);
    step(5);
    check("post_rst_overrun", overrun, 0);
    check("post_rst_drain", exp_q.size(), 0);

    // enable dropped at bit 40, then re-enabled
    send_bits(0, 0, 40);
    enable = 1'b0;
    step(2);
    check("dis_micclk", micClk, 0);
    step(200);
    check("dis_micclk_hold", micClk, 0);
    check("dis_valid", sample_valid, 0);
    micData = 1'b1;
    enable  = 1'b1;
    lat     = 0;
    while (lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (micClk) break;
    end
    check("enable_latency", lat, 25);
    exp_q.push_back(16'h4000);
    sat_q.push_back(16'h7FFF);
    send_bits(1, 1, 63);
    step(5);
    check("final_drain", exp_q.size(), 0);
    check("final_sat_drain", sat_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
